jtag_host_master: RTL and testbench

JTAG_HOST_MASTER -- requirements
Module: jtag_host_master

---
 rtl/jtag_host_master.sv | 167 ++++++++++++++++
 tb/tb_jtag_host_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_master.sv
// JTAG host: executes one TAP command (reset, IR scan, DR scan, idle clocks) per request
// and returns the TDO bits captured during the shift phase; TCK is clk divided by 2*CLK_DIV.
module jtag_host_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_len,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        busy,
    output logic        tap_synced,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i
);
    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_IDLE  = 2'd3;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PRE, S_SHIFT, S_POST, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [6:0]  n_q, n_d, bit_q, bit_d;
    logic [7:0]  div_q, div_d;
    logic [63:0] data_q, data_d, cap_q, cap_d;
    logic        tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, synced_q, synced_d;
    logic        accept, active, half_end, bit_end;

    function automatic logic [6:0] phase_len(input state_t s, input logic [1:0] op, input logic [6:0] n);
        case (s)
            S_SYNC:  return 7'd6;
            S_PRE:   return (op == OP_IR) ? 7'd4 : 7'd3;
            S_SHIFT: return n;
            default: return 7'd2;
        endcase
    endfunction

    function automatic state_t after_sync(input logic [1:0] op);
        case (op)
            OP_RESET: return S_RESP;
            OP_IDLE:  return S_SHIFT;
            default:  return S_PRE;
        endcase
    endfunction

    function automatic logic tms_for(input state_t s, input logic [6:0] b, input logic [1:0] op,
                                     input logic [6:0] n);
        case (s)
            S_SYNC:  return b != 7'd5;
            S_PRE:   return (op == OP_IR) ? (b < 7'd2) : (b == 7'd0);
            S_SHIFT: return (op != OP_IDLE) && (b == n - 7'd1);
            S_POST:  return b == 7'd0;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        accept   = cmd_valid && cmd_ready;
        active   = (state_q != S_IDLE) && (state_q != S_RESP);
        half_end = active && (div_q == DIV_LAST);
        bit_end  = half_end && tck_q;
        state_d  = state_q;
        op_d     = op_q;
        n_d      = n_q;
        data_d   = data_q;
        bit_d    = bit_q;
        div_d    = div_q;
        tck_d    = tck_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;
        synced_d = synced_q;
        cap_d    = cap_q;
        if (active) begin
            div_d = half_end ? 8'd0 : div_q + 8'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    n_d     = (cmd_len == 7'd0) ? 7'd1 : (cmd_len > 7'd64) ? 7'd64 : cmd_len;
                    cap_d   = '0;
                    bit_d   = 7'd0;
                    div_d   = 8'd0;
                    tck_d   = 1'b0;
                    state_d = (cmd_op == OP_RESET || !synced_q) ? S_SYNC : after_sync(cmd_op);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: begin
                if (half_end) begin
                    tck_d = !tck_q;
                    if (!tck_q) begin
                        // rising TCK edge: capture only while shifting a real scan
                        if (state_q == S_SHIFT && op_q != OP_IDLE) cap_d[bit_q[5:0]] = tdo_i;
                    end else if (bit_q == phase_len(state_q, op_q, n_q) - 7'd1) begin
                        bit_d = 7'd0;
                        case (state_q)
                            S_SYNC: begin
                                state_d  = after_sync(op_q);
                                synced_d = 1'b1;
                            end
                            S_PRE:   state_d = S_SHIFT;
                            S_SHIFT: state_d = (op_q == OP_IDLE) ? S_RESP : S_POST;
                            default: state_d = S_RESP;
                        endcase
                    end else begin
                        bit_d = bit_q + 7'd1;
                    end
                end
            end
        endcase
        // TMS/TDI for the next bit are launched with the falling TCK edge (or at accept)
        if (accept || (bit_end && state_d != S_RESP)) begin
            tms_d = tms_for(state_d, bit_d, op_d, n_d);
            tdi_d = (state_d == S_SHIFT && op_d != OP_IDLE) ? data_d[bit_d[5:0]] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 2'd0;
            n_q      <= 7'd1;
            data_q   <= '0;
            bit_q    <= 7'd0;
            div_q    <= 8'd0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            synced_q <= 1'b0;
            cap_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            n_q      <= n_d;
            data_q   <= data_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            tck_q    <= tck_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
            synced_q <= synced_d;
            cap_q    <= cap_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE) && !rst;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_data   = cap_q;
    assign busy       = active;
    assign tap_synced = synced_q;
    assign tck_o      = tck_q;
    assign tms_o      = tms_q;
    assign tdi_o      = tdi_q;
endmodule

// File: tb/tb_jtag_host_master.sv
// Bench for jtag_host_master: a behavioural IEEE 1149.1 target TAP (5-bit IR, IDCODE/BYPASS)
// drives tdo_i; expected TMS/TDI/TDO are derived from the command rules with plain arithmetic.
`timescale 1ns/1ps
module tb_jtag_host_master;
    localparam int          CLK_DIV = 2;
    localparam logic [31:0] IDCODE  = 32'h1DEAD3FF;
    localparam int          TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PAUDR = 6,
                            EX2DR = 7, UPDDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                            PAUIR = 13, UPDIR = 15;

    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [6:0]  cmd_len = 7'd0;
    logic [63:0] cmd_data = 64'd0;
    logic        cmd_ready, rsp_valid, busy, tap_synced, tck_o, tms_o, tdi_o, tdo_i;
    logic [63:0] rsp_data;

    int n_checks = 0, n_pass = 0;

    jtag_host_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .tap_synced(tap_synced), .tck_o(tck_o), .tms_o(tms_o),
        .tdi_o(tdi_o), .tdo_i(tdo_i)
    );

    always #5 clk = ~clk;

    // ---------------- target TAP ----------------
    int          tap_st = SHDR;
    logic [4:0]  ir = 5'd3, ir_sr = 5'd0;
    logic [63:0] dr_sr = 64'd0;
    int          dr_len = 1;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            TLR:         return t ? TLR : RTI;
            RTI:         return t ? SELDR : RTI;
            SELDR:       return t ? SELIR : CAPDR;
            CAPDR, SHDR: return t ? EX1DR : SHDR;
            EX1DR:       return t ? UPDDR : PAUDR;
            PAUDR:       return t ? EX2DR : PAUDR;
            EX2DR:       return t ? UPDDR : SHDR;
            UPDDR, UPDIR: return t ? SELDR : RTI;
            SELIR:       return t ? TLR : CAPIR;
            CAPIR, SHIR: return t ? EX1IR : SHIR;
            EX1IR:       return t ? UPDIR : PAUIR;
            PAUIR:       return t ? 14 : PAUIR;
            default:     return t ? UPDIR : SHIR;
        endcase
    endfunction

    always @(posedge tck_o) begin
        case (tap_st)
            TLR:   ir <= 5'd1;
            CAPDR: begin
                dr_sr  <= (ir == 5'd1) ? 64'(IDCODE) : 64'd0;
                dr_len <= (ir == 5'd1) ? 32 : 1;
            end
            SHDR:  dr_sr <= (dr_sr >> 1) | (64'(tdi_o) << (dr_len - 1));
            CAPIR: ir_sr <= 5'b00001;
            SHIR:  ir_sr <= {tdi_o, ir_sr[4:1]};
            UPDIR: ir <= ir_sr;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms_o);
    end
    assign tdo_i = (tap_st == SHIR) ? ir_sr[0] : dr_sr[0];

    // ---------------- pin monitor ----------------
    logic obs_tms_a [0:16383];
    logic obs_tdi_a [0:16383];
    int   obs_n = 0, glitches = 0;
    logic prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;

    always @(negedge clk) begin
        prev_tck <= tck_o;
        prev_tms <= tms_o;
        prev_tdi <= tdi_o;
        if (prev_tck === 1'b0 && tck_o === 1'b1) begin
            obs_tms_a[obs_n % 16384] <= tms_o;
            obs_tdi_a[obs_n % 16384] <= tdi_o;
            obs_n <= obs_n + 1;
        end
        if (prev_tck === 1'b1 && tck_o === 1'b1 && (tms_o !== prev_tms || tdi_o !== prev_tdi))
            glitches <= glitches + 1;
    end

    // ---------------- reference model ----------------
    logic         m_synced = 1'b0;
    logic [4:0]   m_ir = 5'd1;
    logic [127:0] e_tms, e_tdi, e_mask;
    logic [63:0]  e_rsp;
    int           e_n;

    task automatic push(input logic t, input logic d, input logic m);
        e_tms[e_n]  = t;
        e_tdi[e_n]  = d;
        e_mask[e_n] = m;
        e_n++;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
        int n;
        logic [127:0] full;
        n = (len == 7'd0) ? 1 : (len > 7'd64) ? 64 : int'(len);
        e_tms = '0; e_tdi = '0; e_mask = '0; e_n = 0; e_rsp = '0; full = '0;
        if (op == 2'd0 || !m_synced) begin
            for (int i = 0; i < 6; i++) push(i < 5, 1'b0, 1'b0);
            m_synced = 1'b1;
            m_ir     = 5'd1;
        end
        if (op == 2'd1 || op == 2'd2) begin
            if (op == 2'd1) begin
                push(1'b1, 1'b0, 1'b0); push(1'b1, 1'b0, 1'b0);
                push(1'b0, 1'b0, 1'b0); push(1'b0, 1'b0, 1'b0);
                full = 128'({data, 5'b00001});
            end else begin
                push(1'b1, 1'b0, 1'b0); push(1'b0, 1'b0, 1'b0); push(1'b0, 1'b0, 1'b0);
                full = (m_ir == 5'd1) ? 128'({data, IDCODE}) : 128'({data, 1'b0});
            end
            for (int i = 0; i < n; i++) push(i == n - 1, data[i], 1'b1);
            push(1'b1, 1'b0, 1'b0); push(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < n; i++) e_rsp[i] = full[i];
            if (op == 2'd1) m_ir = full[n +: 5];
        end else if (op == 2'd3) begin
            for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b1);
        end
    endtask

    // ---------------- command driver ----------------
    logic [63:0]  o_rsp;
    logic [127:0] o_tms, o_tdi;
    int           o_tck, o_clks, o_hold_bad;

    task automatic do_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data,
                          input int hold);
        int base, w;
        logic [63:0] first;
        o_rsp = '0; o_tck = -1; o_clks = -1; o_tms = '0; o_tdi = '0; o_hold_bad = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        if (cmd_ready !== 1'b1) begin cmd_valid = 1'b0; return; end
        base = obs_n;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_len = 7'($urandom); cmd_data = {$urandom, $urandom};
        w = 0;
        while (rsp_valid !== 1'b1 && w < 1000) begin @(posedge clk); #1; w++; end
        if (rsp_valid !== 1'b1) return;
        o_clks = w;
        o_tck  = obs_n - base;
        o_rsp  = rsp_data;
        first  = rsp_data;
        for (int i = 0; i < o_tck && i < 128; i++) begin
            o_tms[i] = obs_tms_a[(base + i) % 16384];
            o_tdi[i] = obs_tdi_a[(base + i) % 16384];
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== first || cmd_ready !== 1'b0 || tck_o !== 1'b0 || busy !== 1'b0)
                o_hold_bad++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 7'd8;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_data, busy, tap_synced, tck_o, tms_o, tdi_o} !==
            {1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h busy=%b sync=%b tck=%b tms=%b tdi=%b, expected 0 0 0 0 0 0 1 0",
                     cmd_ready, rsp_valid, rsp_data, busy, tap_synced, tck_o, tms_o, tdi_o);
        end else n_pass++;
        @(negedge clk); cmd_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_release: cmd_ready=%b busy=%b, expected 1 0", cmd_ready, busy);
        end else n_pass++;
    endtask

    task automatic test_tap_reset();
        model_cmd(2'd0, 7'd0, 64'd0);
        do_cmd(2'd0, 7'd0, 64'hFFFF_0000_1234_5678, 0);
        n_checks++;
        if (o_tck !== 6 || o_clks !== 24 || o_tms[5:0] !== 6'b011111 || o_rsp !== 64'd0 || tap_synced !== 1'b1) begin
            $display("FAIL tap_reset: tcks=%0d clks=%0d tms=%b rsp=%h sync=%b, expected 6 24 011111 0 1",
                     o_tck, o_clks, o_tms[5:0], o_rsp, tap_synced);
        end else n_pass++;
    endtask

    task automatic test_ir_scan();
        model_cmd(2'd1, 7'd5, 64'h1);
        do_cmd(2'd1, 7'd5, 64'h1, 0);
        n_checks++;
        if (o_rsp !== 64'h1 || o_tck !== 11 || o_tms[10:0] !== 11'b01100000011) begin
            $display("FAIL ir_scan: rsp=%h tcks=%0d tms=%b, expected 1 11 01100000011", o_rsp, o_tck, o_tms[10:0]);
        end else n_pass++;
        n_checks++;
        if ((o_tdi & e_mask) !== (e_tdi & e_mask) || o_clks !== 4 * e_n) begin
            $display("FAIL ir_scan_tdi: tdi=%h clks=%0d, expected tdi=%h clks=%0d", o_tdi & e_mask, o_clks, e_tdi & e_mask, 4 * e_n);
        end else n_pass++;
    endtask

    task automatic test_dr_idcode();
        model_cmd(2'd2, 7'd32, 64'd0);
        do_cmd(2'd2, 7'd32, 64'd0, 0);
        n_checks++;
        if (o_rsp !== 64'h0000_0000_1DEA_D3FF || o_tck !== 37 || o_tms !== e_tms) begin
            $display("FAIL dr_idcode: rsp=%h tcks=%0d tms=%h, expected 1dead3ff 37 %h", o_rsp, o_tck, o_tms, e_tms);
        end else n_pass++;
    endtask

    task automatic test_rsp_hold();
        logic [63:0] d;
        d = {$urandom, $urandom};
        model_cmd(2'd2, 7'd40, d);
        do_cmd(2'd2, 7'd40, d, 20);
        n_checks++;
        if (o_hold_bad !== 0 || o_rsp !== e_rsp) begin
            $display("FAIL rsp_hold: bad_cycles=%0d rsp=%h, expected 0 %h", o_hold_bad, o_rsp, e_rsp);
        end else n_pass++;
    endtask

    task automatic test_len_bounds();
        logic [63:0] d;
        d = {$urandom, $urandom};
        model_cmd(2'd2, 7'd0, d);
        do_cmd(2'd2, 7'd0, d, 0);
        n_checks++;
        if (o_tck !== 6 || o_rsp !== e_rsp || o_tms !== e_tms) begin
            $display("FAIL len0: tcks=%0d rsp=%h tms=%h, expected 6 %h %h", o_tck, o_rsp, o_tms, e_rsp, e_tms);
        end else n_pass++;
        d = {$urandom, $urandom};
        model_cmd(2'd2, 7'd100, d);
        do_cmd(2'd2, 7'd100, d, 0);
        n_checks++;
        if (o_tck !== 69 || o_rsp !== e_rsp || (o_tdi & e_mask) !== (e_tdi & e_mask)) begin
            $display("FAIL len100: tcks=%0d rsp=%h tdi=%h, expected 69 %h %h", o_tck, o_rsp, o_tdi & e_mask, e_rsp, e_tdi & e_mask);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base, w;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 7'd64; cmd_data = {$urandom, $urandom};
        w = 0;
        while (cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        base = obs_n;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        w = 0;
        while (obs_n - base < 14 && w < 2000) begin @(negedge clk); w++; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({tck_o, tms_o, busy, rsp_valid, tap_synced} !== 5'b01000 || obs_n - base < 14) begin
            $display("FAIL reset_mid: tck=%b tms=%b busy=%b vld=%b sync=%b tcks=%0d, expected 0 1 0 0 0 >=14",
                     tck_o, tms_o, busy, rsp_valid, tap_synced, obs_n - base);
        end else n_pass++;
        @(negedge clk); rst = 1'b0;
        m_synced = 1'b0;
        model_cmd(2'd1, 7'd5, 64'h1);
        do_cmd(2'd1, 7'd5, 64'h1, 0);
        n_checks++;
        if (o_tck !== 17 || o_rsp !== 64'h1 || o_tms !== e_tms) begin
            $display("FAIL reset_resync: tcks=%0d rsp=%h tms=%h, expected 17 1 %h", o_tck, o_rsp, o_tms, e_tms);
        end else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [6:0]  len;
        logic [63:0] d;
        for (int k = 0; k < 24; k++) begin
            op  = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(1, 64));
            d   = {$urandom, $urandom};
            model_cmd(op, len, d);
            do_cmd(op, len, d, $urandom_range(0, 3));
            n_checks++;
            if (o_rsp !== e_rsp) begin
                $display("FAIL rand_rsp[%0d] op=%0d len=%0d: rsp=%h, expected %h", k, op, len, o_rsp, e_rsp);
            end else n_pass++;
            n_checks++;
            if (o_tck !== e_n || o_clks !== 4 * e_n || o_tms !== e_tms || (o_tdi & e_mask) !== (e_tdi & e_mask)) begin
                $display("FAIL rand_seq[%0d] op=%0d len=%0d: tcks=%0d clks=%0d tms=%h tdi=%h, expected %0d %0d %h %h",
                         k, op, len, o_tck, o_clks, o_tms, o_tdi & e_mask, e_n, 4 * e_n, e_tms, e_tdi & e_mask);
            end else n_pass++;
        end
        n_checks++;
        if (glitches !== 0) begin
            $display("FAIL tck_high_stability: changes=%0d, expected 0", glitches);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tap_reset();
        test_ir_scan();
        test_dr_idcode();
        test_rsp_hold();
        test_len_bounds();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
